// File: rtl/iter_cmp_unit.sv
// -----------------------------------------------------------------------------
// iter_cmp_unit
//   Multi-cycle signed/unsigned magnitude comparator. Operands are compared
//   CHUNK bits per cycle, starting with the most significant chunk. The
//   compare stops at the first chunk that differs. A start/busy/done handshake
//   lets a stall unit hold the pipeline. A synchronous flush abandons a
//   compare that is in flight.
//
// Parameters
//   WIDTH      operand width in bits
//   CHUNK      bits compared per cycle (WIDTH % CHUNK == 0, 1 <= CHUNK <= WIDTH)
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high; overrides flush and start
//   start      in   1      compare request, accepted only in IDLE
//   is_signed  in   1      1 = two's-complement compare, sampled with start
//   A, B       in   WIDTH  operands, sampled with start
//   flush      in   1      synchronous abort of a compare in RUN or DONE
//   busy       out  1      high while in RUN
//   done       out  1      one-cycle pulse when CMPout has just been updated
//   CMPout     out  2      00 equal, 01 A>B, 10 A<B
// -----------------------------------------------------------------------------
module iter_cmp_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [1:0]       CMPout
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = $clog2(N) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    localparam logic [1:0] CMP_EQ   = 2'b00;
    localparam logic [1:0] CMP_BIG  = 2'b01;
    localparam logic [1:0] CMP_LESS = 2'b10;

    // Reject impossible chunk configurations at elaboration time.
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("iter_cmp_unit: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so a single unsigned datapath serves both compare modes.
    function automatic logic [WIDTH-1:0] bias_msb(input logic [WIDTH-1:0] v,
                                                  input logic             s);
        bias_msb = v ^ (WIDTH'(s) << (WIDTH - 1));
    endfunction

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_cmp;

    logic [CHUNK-1:0] w_a_top;
    logic [CHUNK-1:0] w_b_top;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;

    // The operand registers are shifted left each RUN cycle, so the chunk
    // under comparison is always the top CHUNK bits.
    assign w_a_top = r_a[WIDTH-1 -: CHUNK];
    assign w_b_top = r_b[WIDTH-1 -: CHUNK];

    if (CHUNK < WIDTH) begin : g_shift
        assign w_a_next = {r_a[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
        assign w_b_next = {r_b[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
    end else begin : g_no_shift
        assign w_a_next = r_a;
        assign w_b_next = r_b;
    end

    // Control FSM with registered busy/done/CMPout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cmp   <= CMP_EQ;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    // A flush arriving with start drops the request.
                    if (start && !flush) begin
                        r_a     <= bias_msb(A, is_signed);
                        r_b     <= bias_msb(B, is_signed);
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_a_top != w_b_top) begin
                        r_cmp   <= (w_a_top > w_b_top) ? CMP_BIG : CMP_LESS;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_idx == LAST_IDX) begin
                        r_cmp   <= CMP_EQ;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_a     <= w_a_next;
                        r_b     <= w_b_next;
                        r_idx   <= r_idx + IDX_W'(1);
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Start is not queued here; flush leads to the same place.
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign CMPout = r_cmp;

endmodule
